count_uart_tx: RTL

COUNT_UART_TX -- requirements
Module: count_uart_tx

---
 rtl/count_uart_tx_pkg.sv | 8 +
 rtl/uart_baud_gen.sv | 27 ++
 rtl/count_uart_tx.sv | 99 +++++++++
 3 files changed

// File: rtl/count_uart_tx_pkg.sv
// Shared types and frame constants for the counter-to-UART transmitter.
package count_uart_tx_pkg;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   localparam int   DATA_BITS   = 8;
   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;
endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts CLKS_PER_BIT-1 down to 0 and reloads on every bit boundary.
module uart_baud_gen #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic bit_done
);
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt;

   // restart aligns the first bit period with the accepting edge
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (restart || (cnt == '0)) begin
         cnt <= RELOAD;
      end else begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign bit_done = (cnt == '0);
endmodule

// File: rtl/count_uart_tx.sv
// Serialises each accepted 8-bit count value as one 8N1 UART frame on a registered tx line.
module count_uart_tx
   import count_uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] count,
   input  logic       count_valid,
   output logic       count_ready,
   output logic       tx,
   output logic       busy
);
   // Handshake: a byte transfers on a rising edge where count_valid and count_ready
   // are both 1; count_ready depends only on state, never on count_valid.

   state_t     state, state_next;
   logic [7:0] shreg, shreg_next;
   logic [2:0] bit_idx, bit_idx_next;
   logic       tx_q, tx_next;
   logic       accept;
   logic       bit_done;

   assign count_ready = (state == IDLE);
   assign accept      = count_valid && count_ready;
   assign busy        = (state != IDLE);
   assign tx          = tx_q;

   uart_baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk      (clk),
      .rst      (rst),
      .restart  (accept),
      .bit_done (bit_done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         shreg   <= '0;
         bit_idx <= '0;
         tx_q    <= STOP_LEVEL;
      end else begin
         state   <= state_next;
         shreg   <= shreg_next;
         bit_idx <= bit_idx_next;
         tx_q    <= tx_next;
      end
   end

   // tx_next is the level of the bit that starts on the following cycle
   always_comb begin
      state_next   = state;
      shreg_next   = shreg;
      bit_idx_next = bit_idx;
      tx_next      = tx_q;
      case (state)
         IDLE: begin
            tx_next = STOP_LEVEL;
            if (accept) begin
               state_next = START;
               tx_next    = START_LEVEL;
               shreg_next = count;
            end
         end
         START: begin
            if (bit_done) begin
               state_next   = DATA;
               tx_next      = shreg[0];
               shreg_next   = {1'b0, shreg[7:1]};
               bit_idx_next = '0;
            end
         end
         DATA: begin
            if (bit_done) begin
               if (bit_idx == 3'(DATA_BITS - 1)) begin
                  state_next = STOP;
                  tx_next    = STOP_LEVEL;
               end else begin
                  bit_idx_next = bit_idx + 3'd1;
                  tx_next      = shreg[0];
                  shreg_next   = {1'b0, shreg[7:1]};
               end
            end
         end
         STOP: begin
            if (bit_done) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
            tx_next    = STOP_LEVEL;
         end
      endcase
   end
endmodule
